// File: rtl/demux_sched_pkg.sv
// rtl/demux_sched_pkg.sv - shared types, widths and helpers for the demux scheduler
package demux_sched_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int NUM_CH     = 8;
  localparam int SEL_WIDTH  = $clog2(NUM_CH);
  localparam int BURST_MAX  = 16;
  localparam int BLEN_WIDTH = $clog2(BURST_MAX + 1);

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    BURST  = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  // A zero length still moves one word; anything past BURST_MAX saturates.
  function automatic logic [BLEN_WIDTH-1:0] clamp_blen(input logic [BLEN_WIDTH-1:0] len);
    logic [BLEN_WIDTH-1:0] res;
    res = len;
    if (len == '0) begin
      res = BLEN_WIDTH'(1);
    end else if (len > BLEN_WIDTH'(BURST_MAX)) begin
      res = BLEN_WIDTH'(BURST_MAX);
    end
    return res;
  endfunction

endpackage

// File: rtl/demux_scheduler_if.sv
// rtl/demux_scheduler_if.sv - input stream and per-channel output handshake bundle
interface demux_scheduler_if;
  import demux_sched_pkg::*;

  logic                  in_valid_i;
  logic [DATA_WIDTH-1:0] in_data_i;
  logic                  in_ready_o;
  logic [DATA_WIDTH-1:0] out_data_o;
  logic [SEL_WIDTH-1:0]  selector_o;
  logic [NUM_CH-1:0]     out_valid_o;
  logic [NUM_CH-1:0]     out_ready_i;

  // Scheduler side.
  modport slave (
    input  in_valid_i, in_data_i, out_ready_i,
    output in_ready_o, out_data_o, selector_o, out_valid_o
  );

  // Upstream source plus downstream demux side.
  modport master (
    output in_valid_i, in_data_i, out_ready_i,
    input  in_ready_o, out_data_o, selector_o, out_valid_o
  );

endinterface

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin search over unmasked channels
module rr_pick
  import demux_sched_pkg::*;
#(
  parameter int N  = NUM_CH,
  parameter int SW = SEL_WIDTH
) (
  input  logic [N-1:0]  mask_i,
  input  logic [SW-1:0] last_grant_i,
  output logic [SW-1:0] grant_o,
  output logic          found_o
);

  // Walk last_grant+1 .. last_grant+N (mod N); the first unmasked channel wins.
  always_comb begin
    logic [SW-1:0] idx;
    logic          found;
    idx     = '0;
    found   = 1'b0;
    grant_o = '0;
    for (int i = 1; i <= N; i++) begin
      idx = last_grant_i + SW'(i);
      if (!found && !mask_i[idx]) begin
        grant_o = idx;
        found   = 1'b1;
      end
    end
    found_o = found;
  end

endmodule

// File: rtl/demux_scheduler.sv
// rtl/demux_scheduler.sv - burst scheduler driving the 8-channel demux selector and handshakes
module demux_scheduler
  import demux_sched_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  srst_i,
  input  logic                  enable_i,
  input  logic                  mode_i,
  input  logic [SEL_WIDTH-1:0]  fixed_sel_i,
  input  logic [BLEN_WIDTH-1:0] burst_len_i,
  input  logic [NUM_CH-1:0]     ch_mask_i,
  demux_scheduler_if.slave      bus,
  output logic                  burst_done_o,
  output logic                  busy_o,
  output logic                  err_o
);

  state_t                  state_q, state_d;
  logic                    hold_q, hold_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [SEL_WIDTH-1:0]    sel_q, sel_d;
  logic [SEL_WIDTH-1:0]    last_q, last_d;
  logic [BLEN_WIDTH-1:0]   count_q, count_d;
  logic [BLEN_WIDTH-1:0]   blen_q, blen_d;

  logic [SEL_WIDTH-1:0]    rr_grant;
  logic                    rr_found;
  logic [SEL_WIDTH-1:0]    pick_sel;
  logic                    pick_ok;
  logic                    out_rdy;
  logic                    xfer;
  logic                    in_rdy;
  logic                    accept;
  logic                    done_pulse;
  logic                    err_pulse;

  rr_pick #(
    .N  (NUM_CH),
    .SW (SEL_WIDTH)
  ) u_rr_pick (
    .mask_i       (ch_mask_i),
    .last_grant_i (last_q),
    .grant_o      (rr_grant),
    .found_o      (rr_found)
  );

  // Destination candidate for the coming burst, only consumed in SEARCH.
  always_comb begin
    pick_sel = rr_grant;
    pick_ok  = rr_found;
    if (mode_i == MODE_FIXED) begin
      pick_sel = fixed_sel_i;
      pick_ok  = !ch_mask_i[fixed_sel_i];
    end
  end

  // Handshake terms: ready passes straight through so a full pipe never bubbles.
  always_comb begin
    out_rdy = bus.out_ready_i[sel_q];
    xfer    = hold_q && out_rdy;
    in_rdy  = (state_q == BURST) && (!hold_q || out_rdy);
    accept  = in_rdy && bus.in_valid_i;
  end

  // Next-state logic for the burst FSM and the single-entry output register.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    last_d     = last_q;
    count_d    = count_q;
    blen_d     = blen_q;
    done_pulse = 1'b0;
    err_pulse  = 1'b0;
    hold_d     = hold_q;
    data_d     = data_q;

    if (accept) begin
      hold_d = 1'b1;
      data_d = bus.in_data_i;
    end else if (xfer) begin
      hold_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (enable_i) begin
          state_d = SEARCH;
        end
      end
      SEARCH: begin
        blen_d = clamp_blen(burst_len_i);
        if (pick_ok) begin
          sel_d   = pick_sel;
          last_d  = pick_sel;
          count_d = '0;
          state_d = BURST;
        end else begin
          err_pulse = 1'b1;
          state_d   = IDLE;
        end
      end
      BURST: begin
        if (accept) begin
          count_d = count_q + BLEN_WIDTH'(1);
          if (count_q == blen_q - BLEN_WIDTH'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (xfer) begin
          done_pulse = 1'b1;
          state_d    = enable_i ? SEARCH : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any held word.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q <= IDLE;
      hold_q  <= 1'b0;
      data_q  <= '0;
      sel_q   <= '0;
      last_q  <= SEL_WIDTH'(NUM_CH - 1);
      count_q <= '0;
      blen_q  <= BLEN_WIDTH'(1);
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      count_q <= count_d;
      blen_q  <= blen_d;
    end
  end

  assign bus.in_ready_o  = in_rdy;
  assign bus.out_data_o  = data_q;
  assign bus.selector_o  = sel_q;
  assign bus.out_valid_o = hold_q ? (NUM_CH'(1) << sel_q) : '0;
  assign burst_done_o    = done_pulse;
  assign err_o           = err_pulse;
  assign busy_o          = (state_q != IDLE);

endmodule

// File: doc/demux_scheduler.md
Name: demux_scheduler

Overview:
Sequences the 8-channel 32b demux. It accepts one valid/ready input stream and drives the demux selector plus a per-channel valid/ready handshake. Words go out in bursts of programmable length, either round-robin over the enabled channels or to one fixed channel. It sits directly upstream of the demux and owns selector_i.

Parameters:
DATA_WIDTH, 32, width of data word
NUM_CH, 8, number of output channels (power of 2)
SEL_WIDTH, 3, $clog2(NUM_CH), selector width
BURST_MAX, 16, maximum burst length in words
BLEN_WIDTH, 5, $clog2(BURST_MAX+1), burst length field width

Ports:
clk_i  in  1  clock, all logic on the rising edge
srst_i  in  1  synchronous reset, active-high
enable_i  in  1  start/continue scheduling bursts
mode_i  in  1  0 = round-robin, 1 = fixed channel
fixed_sel_i  in  SEL_WIDTH  destination in fixed mode
burst_len_i  in  BLEN_WIDTH  words per burst; 0 is treated as 1; values above BURST_MAX saturate to BURST_MAX
ch_mask_i  in  NUM_CH  1 = channel disabled
in_valid_i  in  1  input word valid
in_data_i  in  DATA_WIDTH  input word
in_ready_o  out  1  input accept
out_data_o  out  DATA_WIDTH  registered data to demux channel_in_i
selector_o  out  SEL_WIDTH  registered demux selector
out_valid_o  out  NUM_CH  one-hot valid for channel selector_o
out_ready_i  in  NUM_CH  per-channel ready
burst_done_o  out  1  1-cycle pulse when the last word of a burst transfers out
busy_o  out  1  state != IDLE
err_o  out  1  1-cycle pulse when no legal destination is found

Behaviour:
- Reset (srst_i=1 at the edge):
  - state = IDLE; all outputs 0.
  - out_data_o = 0, selector_o = 0, out_valid_o = 0.
  - last_grant = NUM_CH-1, so the first round-robin grant is ch0.
  - Reset mid-burst drops the held word without a transfer.
- States: IDLE, SEARCH, BURST, DRAIN.
- IDLE -> SEARCH when enable_i=1.
- SEARCH (1 cycle):
  - Latches burst_len_i (after clamping) and mode_i.
  - Round-robin: grant the first channel with mask=0, searching from last_grant+1 with wrap-around.
  - Fixed: grant fixed_sel_i if its mask bit is 0.
  - On a grant: selector_o <= grant, last_grant <= grant, count <= 0, go to BURST.
  - No legal channel (all masked, or fixed channel masked): err_o pulse, go to IDLE.
- Output register: one entry, hold = output word pending.
  - out_valid_o[k] = hold && (selector_o == k).
  - Output transfer occurs when hold && out_ready_i[selector_o].
- BURST:
  - in_ready_o = !hold || out_ready_i[selector_o]. This is a combinational path from ready to ready; no bubble under full throughput.
  - On input accept: out_data_o <= in_data_i, hold <= 1, count++.
  - Latency is 1 cycle: a word accepted at edge N presents on out_valid_o after edge N.
  - When the accepted word is word blen-1, go to DRAIN; in_ready_o is 0 from the next cycle.
- DRAIN: in_ready_o = 0. On the output transfer, burst_done_o pulses, then:
  - enable_i=1 -> SEARCH
  - enable_i=0 -> IDLE
- Simultaneous output transfer and input accept: the hold register is reloaded and hold stays 1.
- Held data and selector are stable while hold && !out_ready_i[selector_o].
- selector_o changes only in SEARCH, so never while hold=1.
- ch_mask_i, mode_i, burst_len_i and fixed_sel_i changes mid-burst are ignored until the next SEARCH.
- enable_i deassert mid-burst: the current burst completes, then IDLE. There is no abort.
- In any state other than BURST, in_ready_o = 0.

Decomposition:
- Package demux_sched_pkg holds:
  - state_t enum {IDLE, SEARCH, BURST, DRAIN}
  - mode constants MODE_RR = 1'b0, MODE_FIXED = 1'b1
  - NUM_CH and SEL_WIDTH defaults
- One sub-module, rr_pick: combinational round-robin search.
  - Inputs: mask, last_grant.
  - Outputs: grant index, found.
- The FSM, counter and output register stay in demux_scheduler.

Test Plan:
1. Reset, then RR mode, burst_len=2, mask=0x00, all ready=1, continuous input 0x1..0x10.
   - ch0 gets 0x1, 0x2; ch1 gets 0x3, 0x4; … ch7 gets 0xF, 0x10.
   - burst_done_o pulses 8 times; the next grant is ch0.
2. RR mode, mask=0xA5 (ch1, 3, 4, 6 enabled), burst_len=1.
   - Grant order is 1, 3, 4, 6, 1.
   - out_valid_o is never set for ch0, 2, 5 or 7.
3. Fixed mode, fixed_sel=5, burst_len=4, out_ready_i[5] toggling 1,0,1,0.
   - Words arrive on ch5 only, in order, with held data stable while ready=0.
   - selector_o stays at 5 for the whole burst.
4. Fixed mode, fixed_sel=2, mask=0x04 -> err_o one pulse, busy_o returns to 0, no out_valid_o.
   - All-masked RR produces the same result.
5. burst_len=0 gives 1 word per burst; burst_len=31 gives 16 words per burst.
   - Deassert enable_i at word 3 of 16: the burst finishes all 16 words, then IDLE.
6. Assert srst_i while hold=1 with ready=0: the next cycle all outputs are 0 and state is IDLE.
   - After re-enable in RR mode, the first grant is ch0.
